// File: rtl/probe_pkg.sv
// rtl/probe_pkg.sv - shared types and helpers for the ap_ctrl latency probe
package probe_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int ID_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } probe_state_e;

    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [CNT_W_DEF-1:0] latency;
        logic [CNT_W_DEF-1:0] interval;
        logic                 incomplete;
        logic                 ready_seen;
    } probe_rec_t;

    // Counters stick at all-ones so a long stall never reads back as a short one.
    function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ap_ctrl_latency_probe_fifo.sv
// rtl/ap_ctrl_latency_probe_fifo.sv - record FIFO, push accepted when full if a pop coincides
module probe_rec_fifo
    import probe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  probe_rec_t push_data,
    input  logic       pop,
    output probe_rec_t head,
    output logic       full,
    output logic       empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    probe_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ap_ctrl_latency_probe.sv
// rtl/ap_ctrl_latency_probe.sv - per-transaction latency/interval profiler for an ap_ctrl_hs block
module ap_ctrl_latency_probe
    import probe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic             rec_incomplete,
    output logic             rec_ready_seen,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic             busy,
    output logic             drained
);

    probe_state_e          state;
    probe_state_e          state_nxt;
    logic [CNT_W_DEF-1:0]  lat_cnt;
    logic [CNT_W_DEF-1:0]  int_cnt;
    logic [CNT_W_DEF-1:0]  int_rec;
    logic [ID_W_DEF-1:0]   id_cnt;
    logic [CNT_W_DEF-1:0]  ovf_cnt;
    logic                  ready_acc;
    logic                  done_ev;
    logic                  open_ev;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    probe_rec_t            rec_in;
    probe_rec_t            head;

    assign done_ev = ap_done && ap_continue;
    assign open_ev = (state == IDLE) && ap_start && !finish;
    assign pop     = rec_valid && rec_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (finish) begin
                    state_nxt = STOPPED;
                end else if (ap_start && !done_ev) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (finish) begin
                    state_nxt = STOPPED;
                end else if (done_ev) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = STOPPED;
        endcase
    end

    always_comb begin
        busy              = (state == RUN);
        drained           = (state == STOPPED) && fifo_empty;
        push              = 1'b0;
        rec_in.id         = id_cnt;
        rec_in.latency    = sat_inc(lat_cnt);
        rec_in.interval   = int_rec;
        rec_in.incomplete = 1'b0;
        rec_in.ready_seen = ready_acc | ap_ready;
        case (state)
            IDLE: begin
                // Combinational module: start and done land on the same edge.
                if (ap_start && done_ev) begin
                    push              = 1'b1;
                    rec_in.latency    = CNT_W_DEF'(1);
                    rec_in.interval   = int_cnt;
                    rec_in.ready_seen = ap_ready;
                end
            end
            RUN: begin
                if (done_ev) begin
                    push = 1'b1;
                end else if (finish) begin
                    push              = 1'b1;
                    rec_in.incomplete = 1'b1;
                end
            end
            default: push = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_cnt   <= '0;
            int_cnt   <= '0;
            int_rec   <= '0;
            id_cnt    <= '0;
            ovf_cnt   <= '0;
            ready_acc <= 1'b0;
        end else begin
            // Zero means no start seen yet, so the interval clock stays parked.
            if (state != STOPPED && int_cnt != '0) begin
                int_cnt <= sat_inc(int_cnt);
            end
            if (state == RUN) begin
                lat_cnt   <= sat_inc(lat_cnt);
                ready_acc <= ready_acc | ap_ready;
            end
            if (open_ev) begin
                lat_cnt   <= CNT_W_DEF'(1);
                int_rec   <= int_cnt;
                int_cnt   <= CNT_W_DEF'(1);
                ready_acc <= ap_ready;
            end
            if (push) begin
                id_cnt <= id_cnt + ID_W_DEF'(1);
            end
            if (push && fifo_full && !pop) begin
                ovf_cnt <= sat_inc(ovf_cnt);
            end
        end
    end

    probe_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rec_valid      = !fifo_empty;
    assign rec_id         = head.id;
    assign rec_latency    = head.latency;
    assign rec_interval   = head.interval;
    assign rec_incomplete = head.incomplete;
    assign rec_ready_seen = head.ready_seen;
    assign overflow_cnt   = ovf_cnt;

endmodule

// File: tb/tb_ap_ctrl_latency_probe.sv
// tb/tb_ap_ctrl_latency_probe.sv - directed self-checking bench for ap_ctrl_latency_probe
module tb_ap_ctrl_latency_probe;

    logic        clock = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        finish;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_id;
    logic [31:0] rec_latency;
    logic [31:0] rec_interval;
    logic        rec_incomplete;
    logic        rec_ready_seen;
    logic [31:0] overflow_cnt;
    logic        busy;
    logic        drained;

    int checks = 0;
    int errors = 0;

    ap_ctrl_latency_probe dut (
        .clock          (clock),
        .reset          (reset),
        .ap_start       (ap_start),
        .ap_ready       (ap_ready),
        .ap_done        (ap_done),
        .ap_continue    (ap_continue),
        .finish         (finish),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_id         (rec_id),
        .rec_latency    (rec_latency),
        .rec_interval   (rec_interval),
        .rec_incomplete (rec_incomplete),
        .rec_ready_seen (rec_ready_seen),
        .overflow_cnt   (overflow_cnt),
        .busy           (busy),
        .drained        (drained)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Start edge, then done after lat-1 further edges; lat==1 means same-edge start+done.
    task automatic txn(input int lat, input logic rdy);
        ap_start = 1'b1;
        ap_ready = rdy;
        if (lat == 1) ap_done = 1'b1;
        tick();
        ap_start = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        if (lat > 1) begin
            repeat (lat - 2) tick();
            ap_done = 1'b1;
            tick();
            ap_done = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] exp_ids [8];
        reset       = 1'b1;
        ap_start    = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        ap_continue = 1'b1;
        finish      = 1'b0;
        rec_ready   = 1'b1;
        do_reset();

        check("rst_valid", rec_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drained", drained, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_id", rec_id, 0);
        check("rst_lat", rec_latency, 0);

        // Single transaction, latency 5
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check("t1_busy", busy, 1);
        repeat (3) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t1_valid", rec_valid, 1);
        check("t1_id", rec_id, 0);
        check("t1_lat", rec_latency, 5);
        check("t1_int", rec_interval, 0);
        check("t1_inc", rec_incomplete, 0);
        check("t1_rs", rec_ready_seen, 0);
        check("t1_busy_low", busy, 0);
        tick();
        check("t1_popped", rec_valid, 0);

        // Back-to-back: starts 7 cycles apart, latency 4 each
        do_reset();
        txn(4, 1'b0);
        check("t2a_id", rec_id, 0);
        check("t2a_lat", rec_latency, 4);
        check("t2a_int", rec_interval, 0);
        repeat (3) tick();
        txn(4, 1'b1);
        check("t2b_valid", rec_valid, 1);
        check("t2b_id", rec_id, 1);
        check("t2b_lat", rec_latency, 4);
        check("t2b_int", rec_interval, 7);
        check("t2b_rs", rec_ready_seen, 1);

        // Same-edge start+done three times in a row
        do_reset();
        for (int i = 0; i < 3; i++) begin
            txn(1, 1'b0);
            check("t3_valid", rec_valid, 1);
            check("t3_id", rec_id, i);
            check("t3_lat", rec_latency, 1);
            check("t3_int", rec_interval, (i == 0) ? 0 : 1);
            check("t3_busy", busy, 0);
        end
        tick();

        // Overflow: 10 transactions into an 8-deep FIFO with no consumer
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) txn(2, 1'b0);
        check("t4_ovf", overflow_cnt, 2);
        check("t4_valid", rec_valid, 1);
        check("t4_head", rec_id, 0);
        check("t4_lat", rec_latency, 2);
        tick();
        check("t4_hold", rec_id, 0);
        // Full FIFO, push and pop on the same edge: push accepted
        rec_ready = 1'b1;
        txn(1, 1'b0);
        check("t4_ovf_same", overflow_cnt, 2);
        exp_ids = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd10};
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_valid", rec_valid, 1);
            check("t4_drain_id", rec_id, exp_ids[i]);
            tick();
        end
        check("t4_empty", rec_valid, 0);

        // Finish mid-run
        do_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (2) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("t5_valid", rec_valid, 1);
        check("t5_lat", rec_latency, 4);
        check("t5_inc", rec_incomplete, 1);
        check("t5_busy", busy, 0);
        check("t5_not_drained", drained, 0);
        tick();
        check("t5_drained", drained, 1);
        ap_start = 1'b1;
        ap_done  = 1'b1;
        repeat (2) tick();
        ap_start = 1'b0;
        ap_done  = 1'b0;
        check("t5_ign_busy", busy, 0);
        check("t5_ign_valid", rec_valid, 0);
        check("t5_still_drained", drained, 1);

        // Done and finish on the same edge: complete record, then stopped
        do_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        ap_done = 1'b1;
        finish  = 1'b1;
        tick();
        ap_done = 1'b0;
        finish  = 1'b0;
        check("t6_valid", rec_valid, 1);
        check("t6_inc", rec_incomplete, 0);
        check("t6_lat", rec_latency, 3);
        tick();
        check("t6_drained", drained, 1);

        // Reset mid-transaction discards everything
        do_reset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_valid", rec_valid, 0);
        check("t7_busy", busy, 0);
        check("t7_lat", rec_latency, 0);
        check("t7_ovf", overflow_cnt, 0);
        txn(3, 1'b0);
        check("t7_id", rec_id, 0);
        check("t7_int", rec_interval, 0);
        check("t7_lat3", rec_latency, 3);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_latency_probe.md
# ap_ctrl_latency_probe

Synthesizable per-module transaction profiler that sits beside one `ap_ctrl_hs` HLS block (e.g. `aes_encrypt_block`) and taps the same `ap_start`/`ap_ready`/`ap_done`/`ap_continue` nets that the simulation monitors sample. It measures each transaction's start-to-done latency and start-to-start interval, then buffers one record per transaction in a small FIFO. Downstream, a readout port is drained by the CSV dump agent in simulation, or by a register bridge on hardware.

## Interface
- `CNT_W`, 32, width of latency/interval counters and records
- `ID_W`, 8, width of transaction sequence number (wraps)
- `DEPTH`, 8, record FIFO depth; power of two, ≥2

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `ap_start`  in  1  tapped start of observed module
- `ap_ready`  in  1  tapped ready (observed only; sets `rec_ready_seen`)
- `ap_done`  in  1  tapped done
- `ap_continue`  in  1  tapped continue; tie 1 for non-dataflow modules
- `finish`  in  1  end-of-run request
- `rec_valid`  out  1  FIFO head valid
- `rec_ready`  in  1  consumer accepts head
- `rec_id`  out  ID_W  transaction sequence number
- `rec_latency`  out  CNT_W  cycles from start to done, inclusive
- `rec_interval`  out  CNT_W  cycles from previous start to this start; 0 for first record
- `rec_incomplete`  out  1  record closed by `finish`, not by done
- `rec_ready_seen`  out  1  `ap_ready` was observed during the transaction
- `overflow_cnt`  out  CNT_W  records dropped because the FIFO was full (saturating)
- `busy`  out  1  transaction open
- `drained`  out  1  finish seen, FSM in STOPPED, FIFO empty

## Operation
- FSM states: IDLE, RUN, STOPPED.
- IDLE:
  - If `ap_start` is high, open a transaction: latency counter := 1, record interval := running interval counter (0 if first), interval counter := 1, go to RUN.
  - If `ap_done && ap_continue` is high in the same cycle, push a record with latency 1 and stay in IDLE.
- RUN:
  - Latency counter increments each cycle.
  - On `ap_done && ap_continue`, push the record and go to IDLE. The next start can be accepted on the following cycle.
  - `ap_start` during RUN is ignored; it is a held level, not a new request.
- The interval counter runs from the first start onward, in every state except STOPPED.
- All counters saturate at all-ones and never wrap. `rec_id` wraps modulo 2^ID_W, starting at 0.
- `finish`, when high in any state, takes effect at the next edge:
  - From RUN: push a record with `rec_incomplete=1` and the latency counted so far, then go to STOPPED.
  - From IDLE: go to STOPPED.
  - STOPPED is exited only by `reset`.
- Push when the FIFO is full: the record is dropped and `overflow_cnt` increments, except when a pop happens in the same cycle, in which case the push is accepted.
- Pop occurs when `rec_valid && rec_ready`.
- `rec_*` outputs are the registered FIFO head; they are held stable while `rec_valid && !rec_ready`.

## Timing
- Record becomes visible on `rec_valid` one cycle after the done (or finish) edge.
- Readout throughput: one record per cycle.
- `busy` is high in the cycle after the start edge and goes low in the cycle after the done edge.
- Reset values:
  - `rec_valid`=0, `busy`=0, `drained`=0.
  - `overflow_cnt`=0, all `rec_*`=0.
  - FSM state IDLE, FIFO empty, id=0.
- Reset asserted mid-transaction: the open transaction and FIFO contents are discarded, with no record pushed.
- `finish` and `ap_done` in the same cycle: done wins. The record is complete (`rec_incomplete=0`), then the FSM goes to STOPPED.

## Structure
- Package `probe_pkg`:
  - `probe_state_e` (IDLE/RUN/STOPPED)
  - `probe_rec_t` packed struct `{id, latency, interval, incomplete, ready_seen}`, parameterised by the package constants `CNT_W_DEF`/`ID_W_DEF`
- Sub-module `probe_rec_fifo`: synchronous FIFO of `probe_rec_t`, DEPTH entries, with full/empty flags and simultaneous push/pop supported when full.
- Top level contains the FSM, the counters and the overflow logic.

## Test plan
- Single transaction: start at cycle 10, done at cycle 14, `rec_ready`=1 → one record `{id=0, latency=5, interval=0, incomplete=0}`, `rec_valid` at cycle 15.
- Back-to-back transactions: starts at cycles 10 and 17, each with latency 4 → second record `{id=1, latency=4, interval=7}`.
- Same-cycle start+done (combinational module) three times → three records with latency 1.
- Overflow: DEPTH=8, `rec_ready`=0, 10 transactions → 8 records held, `overflow_cnt`=2. Then raise `rec_ready` → ids 0..7 drain one per cycle.
- Finish mid-run: start at cycle 10, finish at cycle 13 → record `{latency=4, incomplete=1}`, STOPPED; later `ap_start` is ignored; `drained`=1 once the FIFO is empty.
- Reset at cycle 12 of an open transaction → no record, all outputs 0 at cycle 13, next start counted as id 0.
